cdc_pulse_tx: RTL
=================

Name: cdc_pulse_tx

Overview:
- Transmit end of the toggle-based pulse crossing.
- Converts single-cycle event pulses in the source (iclk) domain into transitions of a level signal that the destination-side toggle receiver synchronises and turns back into pulses.
- Enforces a minimum hold time between transitions so the receiver can never miss one.
- Queues events that arrive while a hold is in progress, with sticky overflow reporting.

Parameters:
HOLD_CYCLES, 4, minimum iclk cycles between successive transitions of o; must be >=1; integrator sizes it to exceed 1.5 destination clock periods
PENDING_WIDTH, 4, width of pending-event counter; queue depth = 2^PENDING_WIDTH-1

Ports:
iclk  input  1  source-domain clock
ireset  input  1  asynchronous, active-high reset
ipulse  input  1  event strobe, one event per cycle high
overflow_clear  input  1  clears sticky overflow
o  output  1  toggle level to cross domains; one transition per event; registered, no logic after flop
busy  output  1  high while in HOLD or pending != 0
pending  output  PENDING_WIDTH  queued events not yet transmitted
overflow  output  1  sticky; an event was dropped

Behaviour:
- Interface (already decided): one clock, iclk; reset ireset is asynchronous and active-high.
- Reset values: o=0, pending=0, overflow=0, busy=0, state=IDLE, timer=0.
- Definition: an event is available at an edge if pending!=0 or ipulse=1.
- State IDLE:
  - If an event is available: toggle o, load timer=HOLD_CYCLES-1, go to HOLD.
  - Otherwise stay in IDLE.
- State HOLD:
  - If timer!=0: decrement timer.
  - If timer==0 and an event is available: toggle o, reload timer=HOLD_CYCLES-1, stay in HOLD.
  - If timer==0 and no event is available: go to IDLE.
- HOLD_CYCLES=1: timer is always 0 and o may toggle on every edge.
- Consumption order: a transmitted event is taken from pending if pending!=0, otherwise from ipulse.
- Pending update per edge: +1 if ipulse is accepted into the queue, -1 if a queued event is transmitted. Simultaneous +1/-1 leaves pending unchanged.
- Latency: ipulse high before edge N with IDLE and pending=0 gives o toggled after edge N (zero added cycles).
- Spacing: successive o transitions are exactly HOLD_CYCLES edges apart when events are backlogged, and never fewer.
- Full queue: when pending==2^PENDING_WIDTH-1 and ipulse=1 with no transmit from the queue that edge, the event is dropped, pending holds, and overflow<=1. Pending never wraps.
- Overflow: overflow_clear clears it. If a drop and overflow_clear coincide, set wins (overflow=1).
- busy is combinational from state and pending; it may also be registered with identical cycle behaviour.
- Reset mid-operation: queued events are discarded and o returns to 0 asynchronously. If o was 1, the receiver sees a spurious transition; system reset sequencing must reset both ends together.
- ipulse is sampled only on iclk edges. No internal synchronisation: ipulse must already be iclk-synchronous.

Test Plan:
- HOLD_CYCLES=4, single ipulse at edge 0 from reset -> o=1 after e0; busy high for e0..e3; state IDLE and busy=0 after e4; pending stays 0.
- HOLD_CYCLES=4, ipulse at edges 0,1,2 -> pending 0,1,2,2,1,1,1,1,0 after e0..e8; o toggles after e0, e4, e8 (1,0,1); no toggle after e12.
- HOLD_CYCLES=8, PENDING_WIDTH=2, ipulse at edges 0..5 -> pending saturates at 3 after e3; overflow=1 after e4; pending remains 3; o toggles after e0, e8, e16, e24, then stops (4 transitions total).
- Overflow set wins: with overflow=1 and the queue full, assert overflow_clear together with a dropped ipulse -> overflow stays 1; assert overflow_clear alone next cycle -> overflow=0.
- Arrival exactly at hold expiry: HOLD_CYCLES=3, ipulse at e0 and e3 -> toggles after e0 and e3; pending remains 0 throughout.
- Reset mid-operation: HOLD_CYCLES=4, ipulse at e0..e2, assert ireset asynchronously between e1 and e2 -> o, pending, busy and overflow go to 0 immediately with no edge required; after release, ipulse at the first edge toggles o to 1 with zero latency.

Source files
------------

// File: rtl/cdc_pulse_tx.sv
// cdc_pulse_tx: transmit end of a toggle-based pulse crossing.
//
// Each single-cycle event on ipulse (iclk domain) becomes one transition of
// the level output o. Successive transitions are spaced at least HOLD_CYCLES
// iclk edges apart so the destination-side synchroniser cannot miss one.
// Events that arrive during a hold are counted in a pending queue. When the
// queue is full, further events are dropped and a sticky overflow flag is set.
//
// Ports:
//   iclk           source-domain clock
//   ireset         asynchronous, active-high reset
//   ipulse         event strobe (iclk-synchronous), one event per high cycle
//   overflow_clear clears the sticky overflow flag (a coincident drop wins)
//   o              registered toggle level to cross domains
//   busy           high while holding or while events are queued
//   pending        number of queued events not yet transmitted
//   overflow       sticky: an event was dropped
module cdc_pulse_tx #(
  parameter int HOLD_CYCLES   = 4,
  parameter int PENDING_WIDTH = 4
) (
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     ipulse,
  input  logic                     overflow_clear,
  output logic                     o,
  output logic                     busy,
  output logic [PENDING_WIDTH-1:0] pending,
  output logic                     overflow
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0]            TIMER_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX   = '1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                   state, state_nxt;
  logic [TW-1:0]            timer, timer_nxt;
  logic [PENDING_WIDTH-1:0] pending_nxt;
  logic                     q_nonempty, avail, fire, take_q, direct, enq, drop;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    fire        = 1'b0;
    take_q      = 1'b0;
    direct      = 1'b0;
    enq         = 1'b0;
    drop        = 1'b0;
    pending_nxt = pending;

    q_nonempty = (pending != '0);
    avail      = q_nonempty | ipulse;

    case (state)
      IDLE: begin
        if (avail) begin
          fire      = 1'b1;
          timer_nxt = TIMER_LOAD;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else if (avail) begin
          fire      = 1'b1;
          timer_nxt = TIMER_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The queue is served first; ipulse bypasses it only when nothing is queued.
    take_q = fire & q_nonempty;
    direct = fire & ~q_nonempty;

    // A full queue can still accept ipulse when a queued event leaves this edge.
    enq  = ipulse & ~direct & ((pending != PEND_MAX) | take_q);
    drop = ipulse & ~direct & (pending == PEND_MAX) & ~take_q;

    case ({enq, take_q})
      2'b10:   pending_nxt = pending + PENDING_WIDTH'(1);
      2'b01:   pending_nxt = pending - PENDING_WIDTH'(1);
      default: pending_nxt = pending;
    endcase

    busy = (state == HOLD) | q_nonempty;
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state    <= IDLE;
      timer    <= '0;
      pending  <= '0;
      o        <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      pending <= pending_nxt;
      o       <= o ^ fire;
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clear)
        overflow <= 1'b0;
    end
  end

endmodule
